// File: rtl/raster_timing_irq_if.sv
// CPU-side register bus for raster_timing_irq: select/strobe/address and the level IRQ.
// The 8-bit data bus is a plain inout port on the block so tristate resolution stays simple.
interface raster_timing_irq_if;
    logic [1:0] address;
    logic       write_enable;
    logic       select;
    logic       irq;

    modport master (output address, output write_enable, output select, input irq);
    modport slave  (input address, input write_enable, input select, output irq);
endinterface

// File: rtl/raster_timing_irq.sv
// Parametrised raster timing generator (counters, sync, window coordinates) with a
// small CPU register file raising maskable vblank-entry, vblank-exit and line-compare IRQs.
module raster_timing_irq #(
    parameter int unsigned H_VISIBLE = 320,
    parameter int unsigned H_FRONT   = 8,
    parameter int unsigned H_SYNC    = 48,
    parameter int unsigned H_BACK    = 24,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned WIN_X0    = 32,
    parameter int unsigned WIN_W     = 256,
    parameter int unsigned WIN_H     = 240,
    parameter int unsigned Y_SHIFT   = 1,
    parameter int unsigned CNT_W     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    raster_timing_irq_if.slave  bus,
    inout  wire  [7:0]          data,
    output logic                hsync,
    output logic                vsync,
    output logic [CNT_W-1:0]    hcounter,
    output logic [CNT_W-1:0]    vcounter,
    output logic                visible,
    output logic                drawing,
    output logic [8:0]          xp,
    output logic [8:0]          yp,
    output logic                writable
);
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_LO = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
    localparam int unsigned V_SYNC_LO = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;
    localparam int unsigned Y_MASK    = (32'd1 << Y_SHIFT) - 32'd1;

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [2:0]       en_q, en_d, pend_q, pend_d, clr, events;
    logic [7:0]       lc_q, lc_d, rdata;
    logic [31:0]      h, v;
    logic             rd_en, wr_en, line_start;

    // Widen once so every comparison against the int parameters is width-matched.
    assign h = 32'(h_q);
    assign v = 32'(v_q);

    always_comb begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
        if (h == H_TOTAL - 1) begin
            h_d = '0;
            v_d = (v == V_TOTAL - 1) ? '0 : v_q + CNT_W'(1);
        end
    end

    assign hcounter = h_q;
    assign vcounter = v_q;
    assign visible  = (h < H_VISIBLE) && (v < V_VISIBLE);
    assign writable = (v >= V_VISIBLE);
    assign hsync    = (h >= H_SYNC_LO && h < H_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    assign vsync    = (v >= V_SYNC_LO && v < V_SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    assign xp       = 9'(h - WIN_X0);
    assign yp       = 9'(v >> Y_SHIFT);
    assign drawing  = visible && (h >= WIN_X0) && (h < WIN_X0 + WIN_W) && (32'(yp) < WIN_H);

    assign line_start = (h == 0);
    assign events[0]  = line_start && (v == V_VISIBLE);
    assign events[1]  = line_start && (v == 0);
    assign events[2]  = line_start && (v < V_VISIBLE) && ((v & Y_MASK) == 0) && (yp[7:0] == lc_q);

    assign rd_en = bus.select && !bus.write_enable;
    assign wr_en = bus.select && bus.write_enable;

    always_comb begin
        en_d = en_q;
        lc_d = lc_q;
        clr  = '0;
        if (wr_en) begin
            case (bus.address)
                2'd1:    en_d = data[2:0];
                2'd2:    clr  = data[2:0];
                2'd3:    lc_d = data;
                default: ;
            endcase
        end
        // OR-ing events after the clear makes a same-cycle set win over W1C.
        pend_d = (pend_q & ~clr) | events;
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            2'd0:    rdata = {5'b0, drawing, (h >= H_VISIBLE), writable};
            2'd1:    rdata = {5'b0, en_q};
            2'd2:    rdata = {5'b0, pend_q};
            default: rdata = lc_q;
        endcase
    end

    assign data    = rd_en ? rdata : 8'hzz;
    assign bus.irq = |(pend_q & en_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            en_q   <= '0;
            pend_q <= '0;
            lc_q   <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            lc_q   <= lc_d;
        end
    end
endmodule

// File: tb/tb_raster_timing_irq.sv
// Self-checking bench for raster_timing_irq in a reduced mode, against a frame-position
// model (t = clocks since reset) plus a register/event model updated each edge.
module tb_raster_timing_irq;
    localparam int HV = 40, HF = 4, HS = 8, HB = 4;
    localparam int VV = 60, VF = 3, VS = 2, VB = 5;
    localparam int X0 = 8, WW = 24, WH = 25, YS = 1, CW = 8;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    raster_timing_irq_if bus ();
    wire  [7:0]    data;
    logic          drv = 1'b0;
    logic [7:0]    wdata = '0;
    assign data = drv ? wdata : 8'hzz;

    logic          hsync, vsync, visible, drawing, writable;
    logic [CW-1:0] hcounter, vcounter;
    logic [8:0]    xp, yp;

    raster_timing_irq #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .WIN_X0(X0), .WIN_W(WW), .WIN_H(WH),
        .Y_SHIFT(YS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .data(data),
        .hsync(hsync), .vsync(vsync), .hcounter(hcounter), .vcounter(vcounter),
        .visible(visible), .drawing(drawing), .xp(xp), .yp(yp), .writable(writable)
    );

    int         vectors = 0;
    int         fails = 0;
    int         t = 0;
    logic [2:0] m_en = '0, m_pend = '0;
    logic [7:0] m_lc = '0;
    logic [7:0] rv;

    function automatic int mh();
        return t % HT;
    endfunction

    function automatic int mv();
        return (t / HT) % VT;
    endfunction

    function automatic logic exp_draw();
        int h = mh();
        int v = mv();
        return (h < HV) && (v < VV) && (h >= X0) && (h < X0 + WW) && (((v >> YS) & 511) < WH);
    endfunction

    function automatic logic [7:0] exp_read(input logic [1:0] a);
        case (a)
            2'd0:    return {5'b0, exp_draw(), mh() >= HV, mv() >= VV};
            2'd1:    return {5'b0, m_en};
            2'd2:    return {5'b0, m_pend};
            default: return m_lc;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic check_outputs();
        int h = mh();
        int v = mv();
        check("hcounter", hcounter, h);
        check("vcounter", vcounter, v);
        check("hsync", hsync, (h >= HV + HF && h < HV + HF + HS) ? 0 : 1);
        check("vsync", vsync, (v >= VV + VF && v < VV + VF + VS) ? 0 : 1);
        check("visible", visible, (h < HV && v < VV) ? 1 : 0);
        check("writable", writable, (v >= VV) ? 1 : 0);
        check("drawing", drawing, exp_draw());
        check("xp", xp, (h - X0) & 511);
        check("yp", yp, (v >> YS) & 511);
        check("irq", bus.irq, |(m_pend & m_en));
        if (bus.select && !bus.write_enable) check("rdata", data, exp_read(bus.address));
        else if (!drv) check("data_hiz", data, 8'hzz);
    endtask

    task automatic tick();
        logic [2:0] ev, clr;
        int h, v;
        @(posedge clk);
        if (rst_n) begin
            h = mh();
            v = mv();
            ev[0] = (h == 0) && (v == VV);
            ev[1] = (h == 0) && (v == 0);
            ev[2] = (h == 0) && (v < VV) && (v % (1 << YS) == 0) && (((v >> YS) & 255) == m_lc);
            clr = '0;
            if (bus.select && bus.write_enable) begin
                case (bus.address)
                    2'd1:    m_en = wdata[2:0];
                    2'd2:    clr = wdata[2:0];
                    2'd3:    m_lc = wdata;
                    default: ;
                endcase
            end
            m_pend = (m_pend & ~clr) | ev;
            t++;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle();
        bus.select = 1'b0;
        bus.write_enable = 1'b0;
        bus.address = 2'd0;
        drv = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.select = 1'b1;
        bus.write_enable = 1'b1;
        bus.address = a;
        wdata = d;
        drv = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [1:0] a, input string tag, output logic [7:0] val);
        bus.select = 1'b1;
        bus.write_enable = 1'b0;
        bus.address = a;
        drv = 1'b0;
        #1;
        val = data;
        check(tag, val, exp_read(a));
        idle();
    endtask

    // Advance until the counters sit at (v, h) for the coming edge.
    task automatic seek(input int v, input int h);
        for (int i = 0; i < HT * VT + 2; i++) begin
            if (mv() == v && mh() == h) break;
            tick();
        end
        check("seek_pos", {16'(vcounter), 16'(hcounter)}, {16'(v), 16'(h)});
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.select = 1'b1;
                bus.write_enable = 1'($urandom_range(0, 1));
                bus.address = 2'($urandom_range(0, 3));
                wdata = (bus.address == 2'd3) ? 8'($urandom_range(0, 35)) : 8'($urandom);
                drv = bus.write_enable;
            end else begin
                idle();
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1;
        check_outputs();
        check("rst_hsync", hsync, 1);
        check("rst_visible", visible, 1);
        check("rst_irq", bus.irq, 0);
        rd(2'd1, "rst_en", rv);
        rd(2'd3, "rst_lc", rv);
        tick();
        @(negedge clk) rst_n = 1'b1;
        rd(2'd2, "rel_pend", rv);
        check("rel_pend_zero", rv, 0);

        rand_cycles(HT * VT * 3 / 2);

        // Vblank-entry IRQ and its W1C.
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h07);
        seek(VV - 1, HT - 1);
        tick();
        check("writable_rise", writable, 1);
        rd(2'd0, "status_vb", rv);
        check("status_vb_val", rv, 8'h01);
        tick();
        rd(2'd2, "e0_pend", rv);
        check("e0_bit0", rv[0], 1);
        check("e0_irq", bus.irq, 1);
        wr(2'd2, 8'h01);
        check("e0_clr_irq", bus.irq, 0);
        rd(2'd2, "e0_clr_pend", rv);

        // Window coordinates.
        seek(VV - 2, X0);
        check("xp_zero", xp, 0);
        check("yp_last", yp, (VV - 2) >> YS);

        // Line compare, masked then enabled.
        wr(2'd1, 8'h00);
        wr(2'd3, 8'd10);
        wr(2'd2, 8'h07);
        seek(20, 0);
        tick();
        rd(2'd2, "lc_pend", rv);
        check("lc_bit2", rv[2], 1);
        check("lc_masked_irq", bus.irq, 0);
        wr(2'd1, 8'h04);
        check("lc_en_irq", bus.irq, 1);
        wr(2'd2, 8'h04);
        seek(22, 1);
        rd(2'd2, "lc_no_refire", rv);
        check("lc_bit2_clear", rv[2], 0);

        // W1C colliding with the vblank-entry event cycle: set wins.
        seek(VV, 0);
        wr(2'd2, 8'h01);
        rd(2'd2, "coll_pend", rv);
        check("coll_bit0", rv[0], 1);
        wr(2'd1, 8'hFD);
        rd(2'd1, "en_fd", rv);
        check("en_fd_val", rv, 8'h05);

        // Asynchronous reset mid-line.
        seek(30, 17);
        #1 rst_n = 1'b0;
        #1;
        t = 0;
        m_en = '0;
        m_pend = '0;
        m_lc = '0;
        check_outputs();
        check("mid_rst_h", hcounter, 0);
        check("mid_rst_irq", bus.irq, 0);
        rd(2'd2, "mid_rst_pend", rv);
        tick();
        @(negedge clk) rst_n = 1'b1;
        rd(2'd2, "mid_rel_pend", rv);
        check("mid_rel_zero", rv, 0);
        rand_cycles(600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
